// File: rtl/imc_param.sv
// imc_param: 2x2 fixed-point matrix inverter built around one shared restoring divider.
// Optional macro IMC_ROUND_EN rounds each quotient to nearest instead of truncating.
module imc_param #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic [WIDTH-1:0] cIn,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] aOut,
  output logic [WIDTH-1:0] bOut,
  output logic [WIDTH-1:0] cOut,
  output logic [WIDTH-1:0] dOut,
  output logic             aOut_sign,
  output logic             bOut_sign,
  output logic             cOut_sign,
  output logic             dOut_sign,
  output logic             done,
  output logic             singular,
  output logic             overflow
);

  localparam int QW = WIDTH + 2*FRAC;
  localparam int PW = 2*WIDTH;
  localparam int DW = 2*WIDTH + 1;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST_BIT = CW'(QW - 1);

  typedef enum logic [2:0] {IDLE, MULT, DET, DIV, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           bit_cnt;
  logic [1:0]              elem;
  logic                    sing_r;

  logic signed [WIDTH-1:0] a_r, b_r, c_r, d_r;
  logic signed [PW-1:0]    ad_r, bc_r;
  logic signed [DW-1:0]    det_c;
  logic [DW-1:0]           det_abs;
  logic [DW-1:0]           det_mag;
  logic                    det_neg;
  logic [QW-1:0]           dq, q_nx;
  logic [DW-1:0]           rem, rem_nx;
  logic [DW:0]             trial;
  logic                    num_neg;
  logic [3:0][WIDTH-1:0]   mag_q;
  logic [3:0]              sgn_q, sat_q;

  logic [1:0]              num_idx;
  logic signed [WIDTH-1:0] num_sel;
  logic                    num_flip;
  logic [WIDTH-1:0]        num_mag;
  logic                    num_neg_c;
  logic [QW:0]             q_fin;
  logic [WIDTH:0]          q_sat;

  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH:0] saturate(input logic [QW:0] q);
    if (|q[QW:WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, q[WIDTH-1:0]};
  endfunction

`ifdef IMC_ROUND_EN
  function automatic logic [QW:0] round_q(input logic [QW-1:0] q,
                                          input logic [DW-1:0] r,
                                          input logic [DW-1:0] dv);
    return {1'b0, q} + {{QW{1'b0}}, ({r, 1'b0} >= {1'b0, dv})};
  endfunction
`endif

  assign det_c   = $signed({ad_r[PW-1], ad_r}) - $signed({bc_r[PW-1], bc_r});
  assign det_abs = det_c[DW-1] ? -det_c : det_c;

  // Numerator order d, -b, -c, a; DET preloads element 0, DIV preloads the next one.
  always_comb begin
    num_idx = (state == DIV) ? elem + 2'd1 : 2'd0;
    case (num_idx)
      2'd0:    begin num_sel = d_r; num_flip = 1'b0; end
      2'd1:    begin num_sel = b_r; num_flip = 1'b1; end
      2'd2:    begin num_sel = c_r; num_flip = 1'b1; end
      default: begin num_sel = a_r; num_flip = 1'b0; end
    endcase
    num_mag   = mag_of(num_sel);
    num_neg_c = (num_sel != '0) && (num_sel[WIDTH-1] ^ num_flip);
  end

  // One restoring step; the low DW bits of the difference are exact when trial >= divisor.
  always_comb begin
    trial = {rem, dq[QW-1]};
    if (trial >= {1'b0, det_mag}) begin
      rem_nx = trial[DW-1:0] - det_mag;
      q_nx   = {dq[QW-2:0], 1'b1};
    end else begin
      rem_nx = trial[DW-1:0];
      q_nx   = {dq[QW-2:0], 1'b0};
    end
`ifdef IMC_ROUND_EN
    q_fin = round_q(q_nx, rem_nx, det_mag);
`else
    q_fin = {1'b0, q_nx};
`endif
    q_sat = saturate(q_fin);
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          a_r <= $signed(aIn);
          b_r <= $signed(bIn);
          c_r <= $signed(cIn);
          d_r <= $signed(dIn);
        end
      end
      MULT: begin
        ad_r <= PW'(a_r) * PW'(d_r);
        bc_r <= PW'(b_r) * PW'(c_r);
      end
      DET: begin
        det_mag <= det_abs;
        det_neg <= det_c[DW-1];
        dq      <= {num_mag, {(2*FRAC){1'b0}}};
        rem     <= '0;
        num_neg <= num_neg_c;
      end
      DIV: begin
        if (bit_cnt == LAST_BIT) begin
          mag_q[elem] <= q_sat[WIDTH-1:0];
          sat_q[elem] <= q_sat[WIDTH];
          sgn_q[elem] <= (q_sat[WIDTH-1:0] != '0) && (num_neg ^ det_neg);
          dq          <= {num_mag, {(2*FRAC){1'b0}}};
          rem         <= '0;
          num_neg     <= num_neg_c;
        end else begin
          dq  <= q_nx;
          rem <= rem_nx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      singular  <= 1'b0;
      overflow  <= 1'b0;
      aOut      <= '0;
      bOut      <= '0;
      cOut      <= '0;
      dOut      <= '0;
      aOut_sign <= 1'b0;
      bOut_sign <= 1'b0;
      cOut_sign <= 1'b0;
      dOut_sign <= 1'b0;
      bit_cnt   <= '0;
      elem      <= '0;
      sing_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= MULT;
            ready <= 1'b0;
          end
        end
        MULT: state <= DET;
        DET: begin
          bit_cnt <= '0;
          elem    <= '0;
          sing_r  <= (det_c == '0);
          state   <= (det_c == '0) ? DONE : DIV;
        end
        DIV: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (elem == 2'd3) state <= DONE;
            else              elem  <= elem + 2'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b1;
          ready     <= 1'b1;
          state     <= IDLE;
          singular  <= sing_r;
          overflow  <= !sing_r && (|sat_q);
          aOut      <= sing_r ? '0 : mag_q[0];
          bOut      <= sing_r ? '0 : mag_q[1];
          cOut      <= sing_r ? '0 : mag_q[2];
          dOut      <= sing_r ? '0 : mag_q[3];
          aOut_sign <= !sing_r && sgn_q[0];
          bOut_sign <= !sing_r && sgn_q[1];
          cOut_sign <= !sing_r && sgn_q[2];
          dOut_sign <= !sing_r && sgn_q[3];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imc_param.sv
// tb_imc_param: directed stimulus for imc_param with a per-cycle arithmetic reference model.
`timescale 1ns/1ps
module tb_imc_param;
  localparam int W      = 16;
  localparam int F      = 8;
  localparam int QW     = W + 2*F;
  localparam int LAT_NS = 3 + 4*QW;
  localparam int LAT_S  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic ready, done, singular, overflow;
  logic [W-1:0] a_out, b_out, c_out, d_out;
  logic a_sg, b_sg, c_sg, d_sg;

  imc_param #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .aIn(a_in), .bIn(b_in), .cIn(c_in), .dIn(d_in),
    .aOut(a_out), .bOut(b_out), .cOut(c_out), .dOut(d_out),
    .aOut_sign(a_sg), .bOut_sign(b_sg), .cOut_sign(c_sg), .dOut_sign(d_sg),
    .done(done), .singular(singular), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][W-1:0] mag;
    logic [3:0]        sgn;
    logic              sing;
    logic              ovf;
  } res_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Inverse of [a b; c d] straight from the Q-format arithmetic definition.
  function automatic res_t model(input logic [W-1:0] a, b, c, d);
    res_t r;
    longint sa, sb, sc, sd, det, adet, n, an, q;
    longint nums[4];
`ifdef IMC_ROUND_EN
    longint rm;
`endif
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    sd = longint'($signed(d));
    det = sa*sd - sb*sc;
    if (det == 0) begin
      r.sing = 1'b1;
      return r;
    end
    adet = (det < 0) ? -det : det;
    nums = '{sd, -sb, -sc, sa};
    for (int i = 0; i < 4; i++) begin
      n  = nums[i];
      an = (n < 0) ? -n : n;
      q  = (an << (2*F)) / adet;
`ifdef IMC_ROUND_EN
      rm = (an << (2*F)) % adet;
      if (2*rm >= adet) q++;
`endif
      if (q >= (longint'(1) << W)) begin
        q = (longint'(1) << W) - 1;
        r.ovf = 1'b1;
      end
      r.mag[i] = q[W-1:0];
      r.sgn[i] = (q != 0) && ((n < 0) != (det < 0));
    end
    return r;
  endfunction

  // Reference tracking: every falling edge compares all outputs with the model's view.
  bit   known = 0, busy = 0, pend = 0, acc_next = 0, rst_next = 0, exp_done = 0;
  int   pend_cyc = 0;
  res_t pend_res = '0, exp_res = '0;

  always @(negedge clk) begin
    exp_done = 1'b0;
    if (rst_next) begin
      known = 1; busy = 0; pend = 0; acc_next = 0; rst_next = 0;
      exp_res = '0;
    end else if (known) begin
      if (acc_next) begin busy = 1; acc_next = 0; end
      if (pend && cyc == pend_cyc) begin
        exp_done = 1'b1; exp_res = pend_res; pend = 0; busy = 0;
      end
    end
    if (known) begin
      chk("done", done, exp_done);
      chk("ready", ready, !busy);
      chk("singular", singular, exp_res.sing);
      chk("overflow", overflow, exp_res.ovf);
      chk("aOut", a_out, exp_res.mag[0]);
      chk("bOut", b_out, exp_res.mag[1]);
      chk("cOut", c_out, exp_res.mag[2]);
      chk("dOut", d_out, exp_res.mag[3]);
      chk("aOut_sign", a_sg, exp_res.sgn[0]);
      chk("bOut_sign", b_sg, exp_res.sgn[1]);
      chk("cOut_sign", c_sg, exp_res.sgn[2]);
      chk("dOut_sign", d_sg, exp_res.sgn[3]);
    end
    if (rst) begin
      rst_next = 1;
    end else if (known && start && !busy) begin
      acc_next = 1;
      pend     = 1;
      pend_res = model(a_in, b_in, c_in, d_in);
      pend_cyc = cyc + 1 + (pend_res.sing ? LAT_S : LAT_NS);
    end
  end

  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, lat);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, b, c, d, output int lat);
    @(posedge clk); #1;
    a_in = a; b_in = b; c_in = c; d_in = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nm, lat);
  endtask

  initial begin
    int   lat;
    int   seen;
    res_t m;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_aOut", a_out, 0);

    m = model(16'h0200, 16'h0200, 16'h0100, 16'h0000);
    chk("model_b", m.mag[1], 32'h0100);
    chk("model_c", m.mag[2], 32'h0080);
    chk("model_dsign", m.sgn[3], 1);
    m = model(16'h0600, 16'h0000, 16'h0000, 16'h0600);
`ifdef IMC_ROUND_EN
    chk("model_round", m.mag[0], 32'h002B);
`else
    chk("model_trunc", m.mag[0], 32'h002A);
`endif

    run_op("inv", 16'h0200, 16'h0200, 16'h0100, 16'h0000, lat);
    chk("inv_lat", lat, 131);
    chk("inv_a", a_out, 32'h0000); chk("inv_as", a_sg, 0);
    chk("inv_b", b_out, 32'h0100); chk("inv_bs", b_sg, 0);
    chk("inv_c", c_out, 32'h0080); chk("inv_cs", c_sg, 0);
    chk("inv_d", d_out, 32'h0100); chk("inv_ds", d_sg, 1);
    chk("inv_sing", singular, 0);  chk("inv_ovf", overflow, 0);

    run_op("ident", 16'h0100, 16'h0000, 16'h0000, 16'h0100, lat);
    chk("ident_a", a_out, 32'h0100); chk("ident_d", d_out, 32'h0100);
    chk("ident_b", b_out, 0);        chk("ident_c", c_out, 0);
    chk("ident_signs", {a_sg, b_sg, c_sg, d_sg}, 0);

    run_op("sing", 16'h0100, 16'h0100, 16'h0100, 16'h0100, lat);
    chk("sing_lat", lat, 3);
    chk("sing_flag", singular, 1); chk("sing_ovf", overflow, 0);
    chk("sing_mags", {a_out, b_out, c_out, d_out}, 0);

    run_op("sat", 16'h0001, 16'h0000, 16'h0000, 16'h0001, lat);
    chk("sat_a", a_out, 32'hFFFF); chk("sat_d", d_out, 32'hFFFF);
    chk("sat_ovf", overflow, 1);

    run_op("round", 16'h0600, 16'h0000, 16'h0000, 16'h0600, lat);
`ifdef IMC_ROUND_EN
    chk("round_a", a_out, 32'h002B);
`else
    chk("round_a", a_out, 32'h002A);
`endif
    chk("round_lat", lat, 131);

    run_op("neg", 16'hFE80, 16'h0040, 16'hFFE0, 16'h0300, lat);
    run_op("minneg", 16'h8000, 16'h0000, 16'h0000, 16'h8000, lat);
    chk("minneg_a", a_out, 32'h0002); chk("minneg_as", a_sg, 1);
    run_op("minb", 16'h0000, 16'h8000, 16'h0100, 16'h0000, lat);
    chk("minb_b", b_out, 32'h0100); chk("minb_c", c_out, 32'h0002);
    chk("minb_cs", c_sg, 1);

    // start pulses while busy must be ignored
    @(posedge clk); #1;
    a_in = 16'h0300; b_in = 16'h0100; c_in = 16'hFF00; d_in = 16'h0200; start = 1'b1;
    @(posedge clk); #1 start = 1'b1; a_in = 16'h7FFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 a_in = 16'h0001; d_in = 16'h0001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy", lat);

    // start held high restarts on the first idle cycle after done
    @(posedge clk); #1;
    a_in = 16'h0180; b_in = 16'h0000; c_in = 16'h0000; d_in = 16'hFF00; start = 1'b1;
    @(posedge clk); #1;
    wait_done("held1", lat);
    chk("held1_lat", lat, 131);
    a_in = 16'h0000; b_in = 16'h0100; c_in = 16'h0100; d_in = 16'h0000;
    @(posedge clk); #1 start = 1'b0;
    chk("held_reaccept", ready, 0);
    wait_done("held2", lat);
    chk("held2_lat", lat, 131);

    // reset 50 cycles into an operation aborts it
    @(posedge clk); #1;
    a_in = 16'h0200; b_in = 16'h0000; c_in = 16'h0000; d_in = 16'h0200; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_mags", {a_out, b_out, c_out, d_out}, 0);
    chk("abort_flags", {singular, overflow, done}, 0);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op("after_abort", 16'h0100, 16'h0000, 16'h0000, 16'h0100, lat);
    chk("after_abort_lat", lat, 131);
    chk("after_abort_a", a_out, 32'h0100);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imc_param.md
IMC_PARAM -- requirements
Module: imc_param

Interface
REQ-001 Parameter: WIDTH, default 16, element width in bits; SHALL be at least 4.
REQ-002 Parameter: FRAC, default 8, fractional bits of the Q format; SHALL satisfy 0 < FRAC < WIDTH.
REQ-003 Port: clk, input, 1, single clock; all logic SHALL be rising-edge clk only.
REQ-004 Port: rst, input, 1, reset that is synchronous and active-high.
REQ-005 Port: start, input, 1, request to invert the presented matrix.
REQ-006 Port: ready, output, 1, block idle and able to accept start.
REQ-007 Port: aIn/bIn/cIn/dIn, input, WIDTH each, two's-complement Q format elements of [a b; c d].
REQ-008 Port: aOut/bOut/cOut/dOut, output, WIDTH each, unsigned magnitude of the inverse elements in the same Q format.
REQ-009 Port: aOut_sign/bOut_sign/cOut_sign/dOut_sign, output, 1 each, 1 = negative.
REQ-010 Port: done, output, 1, single-cycle pulse marking valid results.
REQ-011 Port: singular, output, 1, determinant was zero.
REQ-012 Port: overflow, output, 1, at least one element saturated.

Function
REQ-013 States SHALL be IDLE, MULT, DET, DIV, DONE; ready=1 only in IDLE.
REQ-014 IDLE with start=1 SHALL register all four inputs and go to MULT; start outside IDLE SHALL be ignored.
REQ-015 MULT SHALL form a*d and b*c as full 2*WIDTH signed products in one cycle, then go to DET.
REQ-016 DET SHALL form det = a*d - b*c at 2*WIDTH+1 bits. det==0 -> DONE; otherwise -> DIV.
REQ-017 Numerators SHALL be d, -b, -c, a, giving aOut, bOut, cOut, dOut in that order.
REQ-018 DIV SHALL use one shared restoring divider, 1 quotient bit/cycle, WIDTH+2*FRAC cycles per element, processing the elements sequentially in order a, b, c, d.
REQ-019 Quotient SHALL be (|num| << 2*FRAC) / |det|, truncated toward zero.
REQ-020 A quotient at or above 2^WIDTH SHALL saturate to all-ones and set overflow.
REQ-021 Each sign SHALL be sign(num) XOR sign(det). A zero magnitude SHALL force sign=0.
REQ-022 DONE SHALL assert done for exactly one cycle, update all outputs and flags together, then return to IDLE.
REQ-023 Non-singular latency SHALL be exactly 3 + 4*(WIDTH+2*FRAC) cycles from the start-accept edge to done; this is 131 at the defaults.
REQ-024 Singular latency SHALL be exactly 3 cycles. All magnitudes and signs SHALL be 0, singular=1, and overflow=0.
REQ-025 Outputs, singular and overflow SHALL hold their values until the next done or rst.
REQ-026 start held high SHALL begin a new operation on the first IDLE cycle after DONE.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE and set ready=1.
REQ-028 The same reset SHALL set done=0, singular=0, overflow=0, and all magnitudes and signs to 0.
REQ-029 rst SHALL override start and any in-flight operation, including mid-DIV. No done SHALL follow for the aborted operation.

Configuration
REQ-030 Macro IMC_ROUND_EN defined: after each division, the quotient SHALL be incremented when 2*remainder >= |det|. Saturation SHALL still apply, and latency SHALL be unchanged.
REQ-031 Macro IMC_ROUND_EN undefined: truncation per REQ-019 only, with no rounding logic.

Verification (WIDTH=16, FRAC=8)
REQ-032 Inputs a=0x0200, b=0x0200, c=0x0100, d=0x0000 with start -> done at 131 cycles; aOut=0x0000/+, bOut=0x0100/+, cOut=0x0080/+, dOut=0x0100/-; singular=0, overflow=0.
REQ-033 Identity input a=d=0x0100, b=c=0 -> aOut=dOut=0x0100, bOut=cOut=0, all signs 0.
REQ-034 Singular input a=b=c=d=0x0100 -> done at 3 cycles, singular=1, all outputs 0.
REQ-035 Saturating input a=d=0x0001, b=c=0 -> aOut=dOut=0xFFFF, overflow=1.
REQ-036 Rounding input a=d=0x0600, b=c=0 -> aOut=0x002A without IMC_ROUND_EN and 0x002B with it.
REQ-037 Reset mid-operation: rst pulsed 50 cycles after start -> next cycle ready=1 and outputs 0, with no done pulse. A following start then completes normally.
